// File: rtl/spk_pkg.sv
// Shared definitions for the spike BRAM writer.
//   state_t          : packing FSM states (IDLE, PACK, DONE)
//   words_per_step() : number of RAM words one timestep occupies,
//                      ceil(num_neurons / ram_width)
package spk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned words_per_step(input int unsigned num_neurons,
                                                   input int unsigned ram_width);
        return (num_neurons + ram_width - 1) / ram_width;
    endfunction

endpackage

// File: rtl/spk_bram_writer_if.sv
// Serial spike stream, one neuron per beat.
//   s_valid : source has a spike beat
//   s_ready : sink accepts the beat this cycle
//   s_spk   : spike bit of the current neuron
//   s_last  : current beat is the final neuron of the timestep
// Modports: master = spike source (neuron layer), slave = spk_bram_writer.
interface spk_bram_writer_if;

    logic s_valid;
    logic s_ready;
    logic s_spk;
    logic s_last;

    modport master (
        output s_valid,
        output s_spk,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_spk,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/spk_word_shifter.sv
// LSB-first bit accumulator. Each valid bit lands at the next free position
// of the word; the word is reported complete when the top bit is filled or
// when i_last flags the final bit, and the accumulator then restarts at bit 0
// with all bits cleared, so unused high bits of a partial word read as 0.
//   clk, rst    : clock, synchronous active-high reset
//   i_clr       : discard any partial word and restart at bit 0
//   i_valid     : i_bit is to be accumulated this cycle
//   i_bit       : incoming bit
//   i_last      : this bit closes the word regardless of position
//   o_complete  : combinational strobe, o_word is a finished word this cycle
//   o_word      : accumulated word including the incoming bit
module spk_word_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_last,
    output logic             o_complete,
    output logic [WIDTH-1:0] o_word
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;

    always_comb begin
        o_word        = r_acc;
        o_word[r_cnt] = i_bit;
    end

    assign o_complete = i_valid && ((r_cnt == CW'(WIDTH - 1)) || i_last);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_valid) begin
            if (o_complete) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= o_word;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spk_bram_writer.sv
// Packs a serial spike stream (one neuron per beat) LSB-first into RAM words
// and writes each completed word to the spike BRAM at a running pointer that
// wraps at RAM_DEPTH, so consecutive timesteps fill consecutive word groups.
// Optional feature macro: SPK_COUNT_EN adds the spk_count popcount output.
//   clk, rst    : clock, synchronous active-high reset
//   step_start  : pulse in IDLE arms packing of one timestep
//   s           : spike stream (slave side: s_valid/s_spk/s_last in, s_ready out)
//   wren        : one-cycle BRAM write enable
//   wraddr      : BRAM write address (holds when wren=0)
//   wrdat       : packed spike word (holds when wren=0)
//   step_done   : one-cycle pulse alongside the final write of a timestep
//   len_err     : sticky; final beat did not match NUM_NEURONS, cleared by step_start
//   spk_count   : spikes in the last completed timestep (SPK_COUNT_EN only)
module spk_bram_writer
    import spk_pkg::*;
#(
    parameter int RAM_DEPTH      = 32,
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int NUM_NEURONS    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      step_start,
    spk_bram_writer_if.slave          s,
    output logic                      wren,
    output logic [RAM_ADDR_WIDTH-1:0] wraddr,
    output logic [RAM_WIDTH-1:0]      wrdat,
    output logic                      step_done,
    output logic                      len_err
`ifdef SPK_COUNT_EN
    ,
    output logic [$clog2(NUM_NEURONS+1)-1:0] spk_count
`endif
);

    localparam int unsigned WORDS_PER_STEP = words_per_step(NUM_NEURONS, RAM_WIDTH);
    localparam int          NCW            = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    // One timestep must fit in the BRAM, or it would overwrite itself.
    if (WORDS_PER_STEP > RAM_DEPTH) begin : g_bad_cfg
        $error("spk_bram_writer: one timestep needs more words than RAM_DEPTH");
    end

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_ready;
    logic [NCW-1:0]            r_nrn;
    logic [RAM_ADDR_WIDTH-1:0] r_ptr;
    logic                      r_wren;
    logic [RAM_ADDR_WIDTH-1:0] r_wraddr;
    logic [RAM_WIDTH-1:0]      r_wrdat;
    logic                      r_done;
    logic                      r_len_err;

    logic                      w_start;
    logic                      w_accept;
    logic                      w_at_end;
    logic                      w_final;
    logic                      w_len_bad;
    logic                      w_complete;
    logic [RAM_WIDTH-1:0]      w_word;

    assign w_start   = step_start && (r_state == IDLE);
    // r_ready is high exactly while in PACK, so it doubles as the state qualifier.
    assign w_accept  = s.s_valid && r_ready;
    assign w_at_end  = (r_nrn == NCW'(NUM_NEURONS - 1));
    assign w_final   = w_accept && (s.s_last || w_at_end);
    // Either s_last came early, or the last neuron arrived without s_last.
    assign w_len_bad = w_accept && (s.s_last != w_at_end);

    spk_word_shifter #(
        .WIDTH (RAM_WIDTH)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_start),
        .i_valid    (w_accept),
        .i_bit      (s.s_spk),
        .i_last     (w_final),
        .o_complete (w_complete),
        .o_word     (w_word)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (step_start) w_next = PACK;
            PACK:    if (w_final)    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == PACK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nrn <= '0;
        end else if (w_start) begin
            r_nrn <= '0;
        end else if (w_accept) begin
            r_nrn <= w_final ? '0 : r_nrn + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wren   <= 1'b0;
            r_wraddr <= '0;
            r_wrdat  <= '0;
            r_done   <= 1'b0;
            r_ptr    <= '0;
        end else begin
            r_wren <= w_complete;
            r_done <= w_final;
            if (w_complete) begin
                r_wraddr <= r_ptr;
                r_wrdat  <= w_word;
                r_ptr    <= (r_ptr == RAM_ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_err <= 1'b0;
        end else if (w_start) begin
            r_len_err <= 1'b0;
        end else if (w_len_bad) begin
            r_len_err <= 1'b1;
        end
    end

    assign s.s_ready = r_ready;
    assign wren      = r_wren;
    assign wraddr    = r_wraddr;
    assign wrdat     = r_wrdat;
    assign step_done = r_done;
    assign len_err   = r_len_err;

`ifdef SPK_COUNT_EN
    localparam int CNTW = $clog2(NUM_NEURONS + 1);

    logic [CNTW-1:0] r_pop;
    logic [CNTW-1:0] r_spk_count;
    logic [CNTW-1:0] w_pop_next;

    assign w_pop_next = r_pop + CNTW'(s.s_spk);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pop       <= '0;
            r_spk_count <= '0;
        end else begin
            if (w_start) begin
                r_pop <= '0;
            end else if (w_accept) begin
                r_pop <= w_final ? '0 : w_pop_next;
            end
            if (w_final) begin
                r_spk_count <= w_pop_next;
            end
        end
    end

    assign spk_count = r_spk_count;
`endif

endmodule

// File: tb/tb_spk_bram_writer.sv
// Self-checking bench for spk_bram_writer: a 64-neuron instance (depth 32)
// and a 40-neuron instance (depth 4, for frequent pointer wrap), driven with
// random spike patterns, random idle gaps and stray step_start pulses.
module tb_spk_bram_writer;

    localparam int NA = 64;
    localparam int NB = 40;
    localparam int W  = 32;
    localparam int DA = 32;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_start, b_start;
    logic        a_wren, b_wren;
    logic [4:0]  a_wraddr;
    logic [1:0]  b_wraddr;
    logic [31:0] a_wrdat, b_wrdat;
    logic        a_done, b_done;
    logic        a_err, b_err;
`ifdef SPK_COUNT_EN
    logic [6:0]  a_cnt;
    logic [5:0]  b_cnt;
`endif

    spk_bram_writer_if ifa ();
    spk_bram_writer_if ifb ();

    spk_bram_writer #(
        .RAM_DEPTH   (DA),
        .RAM_WIDTH   (W),
        .NUM_NEURONS (NA)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .step_start (a_start),
        .s          (ifa),
        .wren       (a_wren),
        .wraddr     (a_wraddr),
        .wrdat      (a_wrdat),
        .step_done  (a_done),
        .len_err    (a_err)
`ifdef SPK_COUNT_EN
        ,
        .spk_count  (a_cnt)
`endif
    );

    spk_bram_writer #(
        .RAM_DEPTH   (DB),
        .RAM_WIDTH   (W),
        .NUM_NEURONS (NB)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .step_start (b_start),
        .s          (ifb),
        .wren       (b_wren),
        .wraddr     (b_wraddr),
        .wrdat      (b_wrdat),
        .step_done  (b_done),
        .len_err    (b_err)
`ifdef SPK_COUNT_EN
        ,
        .spk_count  (b_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: next write address and last written address/data per DUT.
    int          ptr[2];
    logic [63:0] exp_addr[2];
    logic [63:0] exp_dat[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic st, input logic v,
                          input logic sp, input logic l);
        if (sel == 0) begin
            a_start = st; ifa.s_valid = v; ifa.s_spk = sp; ifa.s_last = l;
        end else begin
            b_start = st; ifb.s_valid = v; ifb.s_spk = sp; ifb.s_last = l;
        end
    endtask

    task automatic get_out(input int sel, output logic wr, output logic [63:0] addr,
                           output logic [63:0] dat, output logic done,
                           output logic err, output logic rdy, output logic [63:0] cnt);
        wr   = sel ? b_wren : a_wren;
        addr = sel ? 64'(b_wraddr) : 64'(a_wraddr);
        dat  = sel ? 64'(b_wrdat) : 64'(a_wrdat);
        done = sel ? b_done : a_done;
        err  = sel ? b_err : a_err;
        rdy  = sel ? ifb.s_ready : ifa.s_ready;
`ifdef SPK_COUNT_EN
        cnt  = sel ? 64'(b_cnt) : 64'(a_cnt);
`else
        cnt  = '0;
`endif
    endtask

    task automatic chk_zero(input int sel);
        logic wr, done, err, rdy;
        logic [63:0] addr, dat, cnt;
        get_out(sel, wr, addr, dat, done, err, rdy, cnt);
        chk("rst_wren", wr, 0);
        chk("rst_wraddr", addr, 0);
        chk("rst_wrdat", dat, 0);
        chk("rst_done", done, 0);
        chk("rst_len_err", err, 0);
        chk("rst_ready", rdy, 0);
        chk("rst_spk_count", cnt, 0);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            ptr[i] = 0; exp_addr[i] = '0; exp_dat[i] = '0;
        end
    endtask

    // One timestep. last_idx is the beat carrying s_last (-1 or >= N: none).
    // Inputs change on negedge; outputs are checked on the following negedge.
    task automatic run_step(input int sel, input logic [63:0] bits,
                            input int last_idx, input bit dup_start);
        int          n, depth, f, b, pop;
        bit          gap, fin, cmp, exp_err;
        logic [31:0] word;
        logic        wr, done, err, rdy;
        logic [63:0] addr, dat, cnt;

        n       = sel ? NB : NA;
        depth   = sel ? DB : DA;
        f       = (last_idx >= 0 && last_idx < n) ? last_idx : n - 1;
        exp_err = !(f == n - 1 && last_idx == n - 1);

        set_in(sel, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        get_out(sel, wr, addr, dat, done, err, rdy, cnt);
        chk("start_ready", rdy, 1);
        chk("start_len_err_clr", err, 0);
        chk("start_wren", wr, 0);

        word = '0; b = 0; pop = 0;
        while (b <= f) begin
            gap = ($urandom_range(0, 3) == 0);
            if (gap)
                set_in(sel, 1'($urandom_range(0, 1)), 1'b0,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                set_in(sel, 1'b0, 1'b1, bits[b], b == last_idx);
            @(negedge clk);
            get_out(sel, wr, addr, dat, done, err, rdy, cnt);
            fin = 0; cmp = 0;
            if (!gap) begin
                word[b % W] = bits[b];
                pop += int'(bits[b]);
                fin = (b == f);
                cmp = fin || (b % W == W - 1);
            end
            chk("wren", wr, 64'(cmp));
            if (cmp) begin
                exp_addr[sel] = 64'(ptr[sel]);
                exp_dat[sel]  = 64'(word);
                ptr[sel]      = (ptr[sel] + 1) % depth;
                word          = '0;
            end
            chk("wraddr", addr, exp_addr[sel]);
            chk("wrdat", dat, exp_dat[sel]);
            chk("step_done", done, 64'(fin));
            chk("s_ready", rdy, 64'(!fin));
            if (!gap) b++;
        end
        chk("len_err", err, 64'(exp_err));
`ifdef SPK_COUNT_EN
        chk("spk_count", cnt, 64'(pop));
`endif

        // DONE cycle: a step_start here must be ignored.
        set_in(sel, dup_start, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        get_out(sel, wr, addr, dat, done, err, rdy, cnt);
        chk("post_wren", wr, 0);
        chk("post_done", done, 0);
        chk("post_ready", rdy, 0);
        chk("post_len_err", err, 64'(exp_err));
        chk("post_wraddr_hold", addr, exp_addr[sel]);
        chk("post_wrdat_hold", dat, exp_dat[sel]);
        set_in(sel, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        get_out(sel, wr, addr, dat, done, err, rdy, cnt);
        chk("idle_ready", rdy, 0);
        chk("idle_wren", wr, 0);
    endtask

    initial begin
        logic        wr, done, err, rdy;
        logic [63:0] addr, dat, cnt;

        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_model();
        repeat (3) @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        rst = 1'b0;

        // Alternating spikes: 0x55555555 at addr 0 then addr 1.
        run_step(0, 64'h5555_5555_5555_5555, NA - 1, 1'b0);
        chk("alt_addr1", 64'(a_wraddr), 64'd1);
        chk("alt_word1", 64'(a_wrdat), 64'h5555_5555);

        // 40 neurons, only neuron 39 spikes: word 1 = 0x80.
        run_step(1, 64'd1 << 39, NB - 1, 1'b0);
        chk("n39_addr", 64'(b_wraddr), 64'd1);
        chk("n39_word", 64'(b_wrdat), 64'h80);

        // 16 more steps; the 17th lands on addr 0/1 after wrapping.
        for (int i = 0; i < 16; i++)
            run_step(0, {$urandom(), $urandom()}, NA - 1, 1'($urandom_range(0, 1)));
        chk("wrap_addr", 64'(a_wraddr), 64'd1);
        chk("wrap_len_err", 64'(a_err), 64'd0);

        // Early s_last on beat 10, then a clean step clears len_err.
        run_step(0, {$urandom(), $urandom()}, 10, 1'b1);
        chk("early_len_err", 64'(a_err), 64'd1);
        run_step(0, {$urandom(), $urandom()}, NA - 1, 1'b0);

        // Final neuron without s_last.
        run_step(0, {$urandom(), $urandom()}, -1, 1'b0);

        // 40-neuron instance: wrap at depth 4, early and missing s_last.
        for (int i = 0; i < 5; i++)
            run_step(1, {$urandom(), $urandom()}, NB - 1, 1'($urandom_range(0, 1)));
        run_step(1, {$urandom(), $urandom()}, 35, 1'b0);
        run_step(1, {$urandom(), $urandom()}, -1, 1'b0);
        run_step(1, {$urandom(), $urandom()}, 0, 1'b0);

        // Reset after 20 beats: nothing written, outputs cleared, pointer back to 0.
        set_in(0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            set_in(0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            @(negedge clk);
            get_out(0, wr, addr, dat, done, err, rdy, cnt);
            chk("mid_wren", wr, 0);
        end
        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        rst = 1'b0;
        reset_model();
        run_step(0, {$urandom(), $urandom()}, NA - 1, 1'b0);
        chk("after_rst_addr", 64'(a_wraddr), 64'd1);

        // Seven spikes.
        run_step(0, 64'h8000_0100_0004_1023, NA - 1, 1'b0);
`ifdef SPK_COUNT_EN
        chk("popcount7", 64'(a_cnt), 64'd7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
